// File: rtl/rvmyth_dac_bridge.sv
// rvmyth_dac_bridge: turns changes of the rvmyth count output into a queued
// stream of PWM duty-cycle codes, one code per PWM period.
// Build option: RVMYTH_DAC_DROP_OLDEST_EN selects the full-FIFO policy.
// When it is defined, the oldest entry is replaced. When it is undefined,
// which is the default, the new value is dropped.
module rvmyth_dac_bridge #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        count,
    input  logic                     ovf_clr,
    output logic [DATA_W-1:0]        dac_code,
    output logic                     pwm_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] last_count;
    logic [DATA_W-1:0] pcnt;
    logic [DATA_W-1:0] pcnt_nxt;
    logic [DATA_W-1:0] dac_nxt;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              chg;
    logic              full;
    logic              empty;
    logic              pop;
    logic              ovf_evt;
    logic              wr;
    logic              drop;

    // Push/pop decisions and next-state values shared by the registers below.
    always_comb begin
        chg      = (count != last_count);
        full     = (fifo_level == LW'(DEPTH));
        empty    = (fifo_level == '0);
        pop      = (pcnt == '1) && !empty;
        ovf_evt  = chg && full && !pop;
`ifdef RVMYTH_DAC_DROP_OLDEST_EN
        wr       = chg;
        drop     = ovf_evt;
`else
        wr       = chg && !ovf_evt;
        drop     = 1'b0;
`endif
        dac_nxt  = pop ? mem[rptr] : dac_code;
        pcnt_nxt = pcnt + 1'b1;
    end

    // FIFO storage. The contents do not need a reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr)
            mem[wptr] <= count;
    end

    // Control state, pointers, level, PWM and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_count <= '0;
            pcnt       <= '0;
            dac_code   <= '0;
            pwm_out    <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            pcnt     <= pcnt_nxt;
            dac_code <= dac_nxt;
            // The comparison is made against the next counter and code values.
            // This keeps pwm_out aligned with the pcnt value shown in the same cycle.
            pwm_out  <= (pcnt_nxt < dac_nxt);
            if (chg)
                last_count <= count;
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop || drop)
                rptr <= rptr + 1'b1;
            if (wr && !pop && !full)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !wr && !empty)
                fifo_level <= fifo_level - 1'b1;
            if (ovf_evt)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
